// File: rtl/tl_pkg.sv
// Shared TileLink D-channel definitions: opcode encodings, size codes and the
// processed-response record pushed into the response buffer.
package tl_pkg;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_opcode_e;

  // d_size is log2 of the beat byte count
  localparam logic [1:0] TL_SIZE_1B = 2'd0;
  localparam logic [1:0] TL_SIZE_2B = 2'd1;
  localparam logic [1:0] TL_SIZE_4B = 2'd2;
  localparam logic [1:0] TL_SIZE_8B = 2'd3;

  localparam int unsigned TL_MAX_DW = 64;

  typedef struct packed {
    logic [TL_MAX_DW-1:0] data;
    logic [2:0]           opcode;
    logic                 err;
  } tl_rsp_t;

endpackage

// File: rtl/tl_resp_fifo.sv
// First-word-fall-through FIFO with an occupancy count; the head entry is
// visible on data_o whenever count_o is non-zero.
module tl_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer increments wrap modulo DEPTH naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates visibility so stale contents are never consumed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tl_d_channel_rx.sv
// TileLink D-channel receiver: pairs each beat with the metadata of its request,
// aligns and extends the returned data, and buffers the result for the consumer.
module tl_d_channel_rx
  import tl_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_push_i,
  input  logic [$clog2(DW/8)-1:0]  req_offset_i,
  input  logic                     req_unsigned_i,
  output logic                     req_ready_o,
  input  logic                     d_valid_i,
  output logic                     d_ready_o,
  input  logic [2:0]               d_opcode_i,
  input  logic [1:0]               d_size_i,
  input  logic                     d_error_i,
  input  logic [DW-1:0]            d_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DW-1:0]            rsp_data_o,
  output logic [2:0]               rsp_opcode_o,
  output logic                     rsp_err_o
);

  localparam int unsigned OW       = $clog2(DW/8);
  localparam int unsigned MW       = OW + 1;
  localparam int unsigned RW       = DW + 4;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0]  MAX_SIZE = 2'($clog2(DW/8));

  logic          req_fire, beat_fire, have_meta;
  logic [MW-1:0] meta_head;
  logic [CW-1:0] outst_cnt, rsp_cnt;
  logic [RW-1:0] rsp_entry, rsp_head;

  logic [OW-1:0] beat_offset;
  logic          beat_unsigned;
  logic [DW-1:0] shifted, mask, ext;
  logic [6:0]    nbits;
  logic          size_bad, sign;
  tl_rsp_t       rsp;

  // The metadata FIFO occupancy doubles as the outstanding-request counter.
  assign req_ready_o = rst_ni && (outst_cnt < CW'(DEPTH));
  assign d_ready_o   = rst_ni && (rsp_cnt < CW'(DEPTH));
  assign req_fire    = req_push_i && req_ready_o;
  assign beat_fire   = d_valid_i && d_ready_o;
  assign have_meta   = (outst_cnt != '0);

  tl_resp_fifo #(.WIDTH(MW), .DEPTH(DEPTH)) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_fire),
    .data_i  ({req_offset_i, req_unsigned_i}),
    .pop_i   (beat_fire),
    .data_o  (meta_head),
    .count_o (outst_cnt)
  );

  // An unexpected beat is decoded as offset 0, zero-extended, and flagged.
  assign beat_offset   = have_meta ? meta_head[MW-1:1] : '0;
  assign beat_unsigned = have_meta ? meta_head[0] : 1'b1;

  always_comb begin
    shifted = d_data_i >> {beat_offset, 3'b000};
    case (d_size_i)
      TL_SIZE_1B: nbits = 7'd8;
      TL_SIZE_2B: nbits = 7'd16;
      TL_SIZE_4B: nbits = 7'd32;
      TL_SIZE_8B: nbits = 7'd64;
      default:    nbits = 7'd64;
    endcase
    size_bad = (d_size_i > MAX_SIZE);
    mask     = (DW'(1) << nbits) - DW'(1);
    // Isolate the top kept bit: mask XOR (mask >> 1) leaves only its MSB.
    sign     = |(shifted & (mask ^ (mask >> 1)));
    ext      = shifted & mask;
    if (!beat_unsigned && sign) ext = ext | ~mask;

    rsp        = '0;
    rsp.opcode = d_opcode_i;
    rsp.err    = d_error_i || !have_meta || size_bad;
    case (d_opcode_i)
      TL_ACCESS_ACK:      rsp.data = '0;
      TL_ACCESS_ACK_DATA: rsp.data = size_bad ? '0 : TL_MAX_DW'(ext);
      default: begin
        rsp.data = '0;
        rsp.err  = 1'b1;
      end
    endcase
  end

  assign rsp_entry = {DW'(rsp.data), rsp.opcode, rsp.err};

  tl_resp_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (beat_fire),
    .data_i  (rsp_entry),
    .pop_i   (rsp_valid_o && rsp_ready_i),
    .data_o  (rsp_head),
    .count_o (rsp_cnt)
  );

  // Fields read as zero when empty, so nothing stale leaks out during or after reset.
  assign rsp_valid_o  = (rsp_cnt != '0);
  assign rsp_data_o   = rsp_valid_o ? rsp_head[RW-1:4] : '0;
  assign rsp_opcode_o = rsp_valid_o ? rsp_head[3:1]    : '0;
  assign rsp_err_o    = rsp_valid_o && rsp_head[0];

endmodule

// File: tb/tb_tl_d_channel_rx.sv
// Directed bench for tl_d_channel_rx at DW=32, DEPTH=2: extension, alignment,
// backpressure, error beats and mid-operation reset.
module tb_tl_d_channel_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_push_i;
  logic [1:0]  req_offset_i;
  logic        req_unsigned_i;
  logic        req_ready_o;
  logic        d_valid_i;
  logic        d_ready_o;
  logic [2:0]  d_opcode_i;
  logic [1:0]  d_size_i;
  logic        d_error_i;
  logic [31:0] d_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [2:0]  rsp_opcode_o;
  logic        rsp_err_o;

  int checks = 0;
  int errors = 0;

  tl_d_channel_rx #(.DW(32), .DEPTH(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_push_i     (req_push_i),
    .req_offset_i   (req_offset_i),
    .req_unsigned_i (req_unsigned_i),
    .req_ready_o    (req_ready_o),
    .d_valid_i      (d_valid_i),
    .d_ready_o      (d_ready_o),
    .d_opcode_i     (d_opcode_i),
    .d_size_i       (d_size_i),
    .d_error_i      (d_error_i),
    .d_data_i       (d_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_opcode_o   (rsp_opcode_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic push_req(input logic [1:0] off, input logic uns);
    req_push_i = 1'b1; req_offset_i = off; req_unsigned_i = uns;
    @(posedge clk_i); #1;
    req_push_i = 1'b0;
  endtask

  task automatic send_beat(input logic [2:0] op, input logic [1:0] sz, input logic er,
                           input logic [31:0] data);
    int n;
    d_valid_i = 1'b1; d_opcode_i = op; d_size_i = sz; d_error_i = er; d_data_i = data;
    n = 0;
    while (!d_ready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!d_ready_o) begin
      $display("FAIL beat_accept_timeout: d_ready_o=%b after %0d cycles, required 1", d_ready_o, n);
      errors++;
    end
    checks++;
    @(posedge clk_i); #1;
    d_valid_i = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_push_i = 0; req_offset_i = 0; req_unsigned_i = 0;
    d_valid_i = 0; d_opcode_i = 0; d_size_i = 0; d_error_i = 0; d_data_i = 0;
    rsp_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    if (d_ready_o !== 1'b0)    begin $display("FAIL reset_d_ready: got %b required 0", d_ready_o); errors++; end
    checks++;
    if (req_ready_o !== 1'b0)  begin $display("FAIL reset_req_ready: got %b required 0", req_ready_o); errors++; end
    checks++;
    if (rsp_valid_o !== 1'b0)  begin $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid_o); errors++; end
    checks++;
    if ({rsp_data_o, rsp_opcode_o, rsp_err_o} !== 36'h0) begin
      $display("FAIL reset_rsp_fields: got data=%h op=%0d err=%b required all 0", rsp_data_o, rsp_opcode_o, rsp_err_o);
      errors++;
    end
    checks++;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    if (d_ready_o !== 1'b1 || req_ready_o !== 1'b1) begin
      $display("FAIL post_reset_ready: got d_ready=%b req_ready=%b required 1/1", d_ready_o, req_ready_o);
      errors++;
    end
    checks++;
  endtask

  task automatic test_extension();
    // Byte at offset 1 of 0x00008000 is 0x80: signed -> FFFFFF80, unsigned -> 00000080.
    push_req(2'd1, 1'b0);
    send_beat(3'd1, 2'd0, 1'b0, 32'h0000_8000);
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hFFFF_FF80 || rsp_err_o !== 1'b0 || rsp_opcode_o !== 3'd1) begin
      $display("FAIL byte_signed: got v=%b data=%h err=%b op=%0d required 1/ffffff80/0/1",
               rsp_valid_o, rsp_data_o, rsp_err_o, rsp_opcode_o);
      errors++;
    end
    checks++;
    pop_rsp();
    if (rsp_valid_o !== 1'b0) begin $display("FAIL pop_empty: got rsp_valid=%b required 0", rsp_valid_o); errors++; end
    checks++;

    push_req(2'd1, 1'b1);
    send_beat(3'd1, 2'd0, 1'b0, 32'h0000_8000);
    if (rsp_data_o !== 32'h0000_0080 || rsp_err_o !== 1'b0) begin
      $display("FAIL byte_unsigned: got data=%h err=%b required 00000080/0", rsp_data_o, rsp_err_o);
      errors++;
    end
    checks++;
    pop_rsp();

    push_req(2'd2, 1'b0);
    send_beat(3'd1, 2'd1, 1'b0, 32'hABCD_0000);
    if (rsp_data_o !== 32'hFFFF_ABCD || rsp_err_o !== 1'b0) begin
      $display("FAIL half_signed: got data=%h err=%b required ffffabcd/0", rsp_data_o, rsp_err_o);
      errors++;
    end
    checks++;
    pop_rsp();

    push_req(2'd2, 1'b1);
    send_beat(3'd1, 2'd1, 1'b0, 32'hABCD_0000);
    if (rsp_data_o !== 32'h0000_ABCD) begin
      $display("FAIL half_unsigned: got data=%h required 0000abcd", rsp_data_o); errors++;
    end
    checks++;
    pop_rsp();

    push_req(2'd0, 1'b0);
    send_beat(3'd1, 2'd2, 1'b0, 32'h8765_4321);
    if (rsp_data_o !== 32'h8765_4321 || rsp_err_o !== 1'b0) begin
      $display("FAIL word: got data=%h err=%b required 87654321/0", rsp_data_o, rsp_err_o); errors++;
    end
    checks++;
    pop_rsp();
  endtask

  task automatic test_backpressure();
    push_req(2'd0, 1'b1);
    push_req(2'd0, 1'b1);
    if (req_ready_o !== 1'b0) begin $display("FAIL req_full: got req_ready=%b required 0", req_ready_o); errors++; end
    checks++;
    send_beat(3'd1, 2'd2, 1'b0, 32'h1111_1111);
    send_beat(3'd1, 2'd2, 1'b0, 32'h2222_2222);
    if (d_ready_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL rsp_full: got d_ready=%b req_ready=%b required 0/1", d_ready_o, req_ready_o); errors++;
    end
    checks++;

    push_req(2'd0, 1'b1);
    d_valid_i = 1'b1; d_opcode_i = 3'd1; d_size_i = 2'd2; d_error_i = 1'b0; d_data_i = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      if (d_ready_o !== 1'b0 || rsp_data_o !== 32'h1111_1111) begin
        $display("FAIL stall_%0d: got d_ready=%b head=%h required 0/11111111", i, d_ready_o, rsp_data_o);
        errors++;
      end
      checks++;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    if (d_ready_o !== 1'b1 || rsp_data_o !== 32'h2222_2222) begin
      $display("FAIL after_pop: got d_ready=%b head=%h required 1/22222222", d_ready_o, rsp_data_o); errors++;
    end
    checks++;
    @(posedge clk_i); #1;
    d_valid_i = 1'b0;
    pop_rsp();
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h3333_3333 || rsp_err_o !== 1'b0) begin
      $display("FAIL third_beat: got v=%b data=%h err=%b required 1/33333333/0", rsp_valid_o, rsp_data_o, rsp_err_o);
      errors++;
    end
    checks++;
    pop_rsp();
    if (rsp_valid_o !== 1'b0) begin $display("FAIL drained: got rsp_valid=%b required 0", rsp_valid_o); errors++; end
    checks++;
  endtask

  task automatic test_back_to_back();
    push_req(2'd0, 1'b1);
    // Request push and beat in one cycle leaves one request outstanding.
    req_push_i = 1'b1; req_offset_i = 2'd0; req_unsigned_i = 1'b1;
    d_valid_i = 1'b1; d_opcode_i = 3'd1; d_size_i = 2'd2; d_error_i = 1'b0; d_data_i = 32'hA5A5_A5A5;
    @(posedge clk_i); #1;
    req_push_i = 1'b0;
    if (req_ready_o !== 1'b1 || rsp_data_o !== 32'hA5A5_A5A5 || rsp_err_o !== 1'b0) begin
      $display("FAIL push_and_beat: got req_ready=%b data=%h err=%b required 1/a5a5a5a5/0", req_ready_o, rsp_data_o, rsp_err_o);
      errors++;
    end
    checks++;
    d_data_i = 32'h5A5A_5A5A; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    d_valid_i = 1'b0; rsp_ready_i = 1'b0;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h5A5A_5A5A || d_ready_o !== 1'b1) begin
      $display("FAIL push_and_pop: got v=%b data=%h d_ready=%b required 1/5a5a5a5a/1", rsp_valid_o, rsp_data_o, d_ready_o);
      errors++;
    end
    checks++;
    pop_rsp();
  endtask

  task automatic test_no_outstanding();
    send_beat(3'd0, 2'd2, 1'b0, 32'hDEAD_BEEF);
    if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0 || rsp_opcode_o !== 3'd0) begin
      $display("FAIL orphan_ack: got err=%b data=%h op=%0d required 1/00000000/0", rsp_err_o, rsp_data_o, rsp_opcode_o);
      errors++;
    end
    checks++;
    pop_rsp();
    push_req(2'd0, 1'b1);
    if (req_ready_o !== 1'b1) begin $display("FAIL orphan_count_1: got req_ready=%b required 1", req_ready_o); errors++; end
    checks++;
    push_req(2'd0, 1'b1);
    if (req_ready_o !== 1'b0) begin $display("FAIL orphan_count_2: got req_ready=%b required 0", req_ready_o); errors++; end
    checks++;
    send_beat(3'd1, 2'd0, 1'b0, 32'h0000_0044);
    pop_rsp();
    send_beat(3'd1, 2'd0, 1'b0, 32'h0000_0044);
    pop_rsp();
  endtask

  task automatic test_bad_beats();
    push_req(2'd0, 1'b1);
    send_beat(3'd1, 2'd3, 1'b0, 32'hFFFF_FFFF);
    if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0) begin
      $display("FAIL size3: got err=%b data=%h required 1/00000000", rsp_err_o, rsp_data_o); errors++;
    end
    checks++;
    pop_rsp();
    push_req(2'd0, 1'b1);
    send_beat(3'd4, 2'd2, 1'b0, 32'h1234_5678);
    if (rsp_err_o !== 1'b1 || rsp_opcode_o !== 3'd4) begin
      $display("FAIL bad_opcode: got err=%b op=%0d required 1/4", rsp_err_o, rsp_opcode_o); errors++;
    end
    checks++;
    pop_rsp();
    push_req(2'd0, 1'b1);
    send_beat(3'd1, 2'd2, 1'b1, 32'h1234_5678);
    if (rsp_err_o !== 1'b1) begin $display("FAIL d_error: got err=%b required 1", rsp_err_o); errors++; end
    checks++;
    pop_rsp();
  endtask

  task automatic test_mid_reset();
    push_req(2'd0, 1'b1);
    push_req(2'd0, 1'b1);
    send_beat(3'd1, 2'd2, 1'b0, 32'h0000_0011);
    send_beat(3'd1, 2'd2, 1'b0, 32'h0000_0022);
    push_req(2'd0, 1'b0);
    rst_ni = 1'b0;
    #1;
    if ({rsp_valid_o, d_ready_o, req_ready_o, rsp_data_o, rsp_opcode_o, rsp_err_o} !== 39'h0) begin
      $display("FAIL mid_reset_outputs: got v=%b d_rdy=%b r_rdy=%b data=%h op=%0d err=%b required all 0",
               rsp_valid_o, d_ready_o, req_ready_o, rsp_data_o, rsp_opcode_o, rsp_err_o);
      errors++;
    end
    checks++;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    if (rsp_valid_o !== 1'b0 || d_ready_o !== 1'b1 || req_ready_o !== 1'b1) begin
      $display("FAIL mid_reset_release: got v=%b d_ready=%b req_ready=%b required 0/1/1", rsp_valid_o, d_ready_o, req_ready_o);
      errors++;
    end
    checks++;
    // The signed request pushed before reset must be gone: beat decodes as orphan.
    send_beat(3'd1, 2'd0, 1'b0, 32'h0000_0080);
    if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0000_0080) begin
      $display("FAIL meta_discarded: got err=%b data=%h required 1/00000080", rsp_err_o, rsp_data_o); errors++;
    end
    checks++;
    pop_rsp();
  endtask

  initial begin
    test_reset();
    test_extension();
    test_backpressure();
    test_back_to_back();
    test_no_outstanding();
    test_bad_beats();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
